// File: rtl/kmkz_pkg.sv
// Shared types and widths for the kamikaze instruction-bus bridge.
package kmkz_pkg;

  localparam int unsigned IBUS_TAG_W  = 30;
  localparam int unsigned KMKZ_WORD_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ibus_state_t;

  typedef struct packed {
    logic                   valid;
    logic                   err;
    logic [IBUS_TAG_W-1:0]  tag;
    logic [KMKZ_WORD_W-1:0] data;
  } ibus_entry_t;

  // Word tag of a byte address (drops the byte offset).
  function automatic logic [IBUS_TAG_W-1:0] word_tag(input logic [KMKZ_WORD_W-1:0] a);
    return a[KMKZ_WORD_W-1:2];
  endfunction

endpackage

// File: rtl/kamikaze_ibus_tagbuf.sv
// Two-entry tagged word buffer: combinational lookup and hit mux, synchronous
// fill/flush, and an LRU bit that points at the entry not most recently hit.
// Ports:
//   clk_i, rst_i      clock, async active-low reset
//   look_tag          tag of the fetch address
//   pf_tag            tag of the sequential successor (prefetch candidate)
//   flush             invalidate both entries next edge (wins over fill)
//   we, widx, wentry  fill port
//   hit, hit_idx      look_tag present and which entry holds it
//   hit_data, hit_err payload of the hit entry, zero on miss
//   pf_hit            pf_tag already present
//   lru               entry to replace on a demand miss
module kamikaze_ibus_tagbuf
  import kmkz_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [IBUS_TAG_W-1:0]  look_tag,
  input  logic [IBUS_TAG_W-1:0]  pf_tag,
  input  logic                   flush,
  input  logic                   we,
  input  logic                   widx,
  input  ibus_entry_t            wentry,
  output logic                   hit,
  output logic                   hit_idx,
  output logic [KMKZ_WORD_W-1:0] hit_data,
  output logic                   hit_err,
  output logic                   pf_hit,
  output logic                   lru
);

  ibus_entry_t ent [2];
  logic [1:0]  look_match;
  logic [1:0]  pf_match;

  // Tag compare for both the demand and the prefetch candidate.
  always_comb begin
    look_match = '0;
    pf_match   = '0;
    for (int i = 0; i < 2; i++) begin
      look_match[i] = ent[i].valid && (ent[i].tag == look_tag);
      pf_match[i]   = ent[i].valid && (ent[i].tag == pf_tag);
    end
  end

  // Tags are kept unique, so at most one match bit is ever set.
  assign hit      = |look_match;
  assign hit_idx  = look_match[1];
  assign pf_hit   = |pf_match;
  assign hit_data = hit ? ent[hit_idx].data : '0;
  assign hit_err  = hit & ent[hit_idx].err;

  // Entry storage.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 2; i++) ent[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < 2; i++) ent[i].valid <= 1'b0;
    end else if (we) begin
      ent[widx] <= wentry;
    end
  end

  // LRU tracks the entry not hit most recently.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lru <= 1'b0;
    end else if (hit) begin
      lru <= ~hit_idx;
    end
  end

endmodule

// File: rtl/kamikaze_ibus_bridge.sv
// Instruction-bus front end for the fetch FIFO. Serves words from a 2-entry
// buffer, issues single Wishbone-classic reads on a miss, prefetches the next
// word when idle, and reports bus errors/timeouts as faulted entries.
// Ports:
//   clk_i, rst_i            clock, async active-low reset
//   addr_i, flush_i         fetch address, buffer invalidate
//   ir_o, ready_o, fault_o  combinational lookup result for addr_i
//   ibus_*                  Wishbone-classic read master
module kamikaze_ibus_bridge
  import kmkz_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 64,
  parameter bit          PREFETCH = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [KMKZ_WORD_W-1:0] addr_i,
  input  logic                   flush_i,
  output logic [KMKZ_WORD_W-1:0] ir_o,
  output logic                   ready_o,
  output logic                   fault_o,
  output logic [KMKZ_WORD_W-1:0] ibus_adr_o,
  output logic                   ibus_cyc_o,
  output logic                   ibus_stb_o,
  input  logic [KMKZ_WORD_W-1:0] ibus_dat_i,
  input  logic                   ibus_ack_i,
  input  logic                   ibus_err_i
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  ibus_state_t state_q, state_d;

  logic [IBUS_TAG_W-1:0]  dem_tag;
  logic [IBUS_TAG_W-1:0]  pf_tag;
  logic                   hit;
  logic                   hit_idx;
  logic                   pf_hit;
  logic                   lru;
  logic [KMKZ_WORD_W-1:0] hit_data;
  logic                   hit_err;

  logic                   cyc_q;
  logic [KMKZ_WORD_W-1:0] adr_q;
  logic                   victim_q;
  logic [IBUS_TAG_W-1:0]  req_tag_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   drop_q;

  logic                   issue;
  logic [IBUS_TAG_W-1:0]  issue_tag;
  logic                   issue_victim;
  logic                   done;
  logic                   timeout;
  logic                   fill_err;
  logic [KMKZ_WORD_W-1:0] fill_data;
  logic                   fill_we;
  ibus_entry_t            fill_entry;

  logic                   unused_addr_bits;
  assign unused_addr_bits = ^addr_i[1:0];

  // Tag arithmetic wraps naturally at 30 bits, so 0xFFFF_FFFC + 4 -> 0.
  assign dem_tag = word_tag(addr_i);
  assign pf_tag  = dem_tag + IBUS_TAG_W'(1);

  assign timeout = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  kamikaze_ibus_tagbuf u_tagbuf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .look_tag (dem_tag),
    .pf_tag   (pf_tag),
    .flush    (flush_i),
    .we       (fill_we),
    .widx     (victim_q),
    .wentry   (fill_entry),
    .hit      (hit),
    .hit_idx  (hit_idx),
    .hit_data (hit_data),
    .hit_err  (hit_err),
    .pf_hit   (pf_hit),
    .lru      (lru)
  );

  assign ready_o = hit;
  assign ir_o    = hit_data;
  assign fault_o = hit_err;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: demand beats prefetch; flush suppresses any new issue.
  always_comb begin
    state_d      = state_q;
    issue        = 1'b0;
    issue_tag    = dem_tag;
    issue_victim = lru;
    done         = 1'b0;
    fill_err     = 1'b0;
    fill_data    = '0;
    unique case (state_q)
      IDLE: begin
        if (!flush_i) begin
          if (!hit) begin
            issue        = 1'b1;
            issue_tag    = dem_tag;
            issue_victim = lru;
          end else if (PREFETCH && !pf_hit) begin
            issue        = 1'b1;
            issue_tag    = pf_tag;
            issue_victim = ~hit_idx;
          end
        end
        if (issue) state_d = BUSY;
      end
      BUSY: begin
        // err dominates a simultaneous ack; faulted entries carry no data.
        if (ibus_err_i) begin
          done     = 1'b1;
          fill_err = 1'b1;
        end else if (ibus_ack_i) begin
          done      = 1'b1;
          fill_data = ibus_dat_i;
        end else if (timeout) begin
          done     = 1'b1;
          fill_err = 1'b1;
        end
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A fill flushed now or earlier in this transaction is discarded.
  assign fill_we    = done && !drop_q && !flush_i;
  assign fill_entry = '{valid: 1'b1, err: fill_err, tag: req_tag_q, data: fill_data};

  // Bus request registers, timeout counter and drop flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cyc_q     <= 1'b0;
      adr_q     <= '0;
      victim_q  <= 1'b0;
      req_tag_q <= '0;
      cnt_q     <= '0;
      drop_q    <= 1'b0;
    end else begin
      if (issue) begin
        cyc_q     <= 1'b1;
        adr_q     <= {issue_tag, 2'b00};
        victim_q  <= issue_victim;
        req_tag_q <= issue_tag;
        cnt_q     <= '0;
        drop_q    <= 1'b0;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (done) begin
          cyc_q  <= 1'b0;
          drop_q <= 1'b0;
        end else if (flush_i) begin
          drop_q <= 1'b1;
        end
      end
    end
  end

  assign ibus_cyc_o = cyc_q;
  assign ibus_stb_o = cyc_q;
  assign ibus_adr_o = adr_q;

endmodule

// File: tb/tb_kamikaze_ibus_bridge.sv
// Directed bench for kamikaze_ibus_bridge (TIMEOUT=8, PREFETCH=1).
module tb_kamikaze_ibus_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] addr_i;
  logic        flush_i;
  logic [31:0] ir_o;
  logic        ready_o;
  logic        fault_o;
  logic [31:0] ibus_adr_o;
  logic        ibus_cyc_o;
  logic        ibus_stb_o;
  logic [31:0] ibus_dat_i;
  logic        ibus_ack_i;
  logic        ibus_err_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  kamikaze_ibus_bridge #(.TIMEOUT(8), .PREFETCH(1'b1)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .addr_i     (addr_i),
    .flush_i    (flush_i),
    .ir_o       (ir_o),
    .ready_o    (ready_o),
    .fault_o    (fault_o),
    .ibus_adr_o (ibus_adr_o),
    .ibus_cyc_o (ibus_cyc_o),
    .ibus_stb_o (ibus_stb_o),
    .ibus_dat_i (ibus_dat_i),
    .ibus_ack_i (ibus_ack_i),
    .ibus_err_i (ibus_err_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic        flush;
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic        rdy;
    logic [31:0] ir;
    logic        flt;
    logic        cyc;
    logic [31:0] adr;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic f, input logic ak,
                       input logic er, input logic [31:0] d);
    addr_i     = a;
    flush_i    = f;
    ibus_ack_i = ak;
    ibus_err_i = er;
    ibus_dat_i = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic rdy, input logic [31:0] ir,
                         input logic flt, input logic cyc, input logic [31:0] adr);
    chk({nm, ".ready"}, 32'(ready_o), 32'(rdy));
    chk({nm, ".ir"}, ir_o, ir);
    chk({nm, ".fault"}, 32'(fault_o), 32'(flt));
    chk({nm, ".cyc"}, 32'(ibus_cyc_o), 32'(cyc));
    chk({nm, ".stb"}, 32'(ibus_stb_o), 32'(cyc));
    chk({nm, ".adr"}, ibus_adr_o, adr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // Cold miss, prefetch, sequential hit, error and ack+err fills.
    //            addr          fl    ack   err   dat             rdy   ir              flt   cyc   adr
    vt[0]  = '{32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
    vt[1]  = '{32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 1'b1, 32'h100};
    vt[2]  = '{32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0000_0013,  1'b0, 32'h0,          1'b0, 1'b1, 32'h100};
    vt[3]  = '{32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0013,  1'b0, 1'b0, 32'h100};
    vt[4]  = '{32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0040_0093,  1'b1, 32'h0000_0013,  1'b0, 1'b1, 32'h104};
    vt[5]  = '{32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0040_0093,  1'b0, 1'b0, 32'h104};
    vt[6]  = '{32'h0000_0104, 1'b0, 1'b1, 1'b0, 32'h0080_0113,  1'b1, 32'h0040_0093,  1'b0, 1'b1, 32'h108};
    vt[7]  = '{32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 1'b0, 32'h108};
    vt[8]  = '{32'h0000_0200, 1'b0, 1'b0, 1'b1, 32'h0,          1'b0, 32'h0,          1'b0, 1'b1, 32'h200};
    vt[9]  = '{32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0,          1'b1, 1'b0, 32'h200};
    vt[10] = '{32'h0000_0200, 1'b0, 1'b1, 1'b1, 32'h0000_0055,  1'b1, 32'h0,          1'b1, 1'b1, 32'h204};
    vt[11] = '{32'h0000_0204, 1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0,          1'b1, 1'b0, 32'h204};
    vt[12] = '{32'h0000_0204, 1'b0, 1'b1, 1'b0, 32'h1234_5678,  1'b1, 32'h0,          1'b1, 1'b1, 32'h208};
    vt[13] = '{32'h0000_0208, 1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h1234_5678,  1'b0, 1'b0, 32'h208};
    vt[14] = '{32'h0000_0208, 1'b0, 1'b1, 1'b0, 32'h0000_000A,  1'b1, 32'h1234_5678,  1'b0, 1'b1, 32'h20C};
    vt[15] = '{32'h0000_0208, 1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h1234_5678,  1'b0, 1'b0, 32'h20C};

    rst_i = 1'b0;
    drive(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].addr, vt[i].flush, vt[i].ack, vt[i].err, vt[i].dat);
      chk_out($sformatf("row%0d", i), vt[i].rdy, vt[i].ir, vt[i].flt, vt[i].cyc, vt[i].adr);
      step();
    end

    // Timeout: no response for 8 BUSY cycles forces a faulted fill.
    drive(32'h400, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("to_miss", 1'b0, 32'h0, 1'b0, 1'b0, 32'h20C);
    step();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("to_busy%0d.cyc", i), 32'(ibus_cyc_o), 32'h1);
      chk($sformatf("to_busy%0d.adr", i), ibus_adr_o, 32'h400);
      step();
    end
    // Flush in the fill-visible cycle: no prefetch may be issued.
    drive(32'h400, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("to_fill", 1'b1, 32'h0, 1'b1, 1'b0, 32'h400);
    step();

    // Flush while BUSY on 0x300: late ack is discarded, demand reissued.
    drive(32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("fl_idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h400);
    step();
    drive(32'h300, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("fl_cyc", 1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
    step();
    drive(32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("fl_wait", 1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
    step();
    drive(32'h300, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk_out("fl_ack", 1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
    step();
    drive(32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("fl_drop", 1'b0, 32'h0, 1'b0, 1'b0, 32'h300);
    step();
    drive(32'h300, 1'b0, 1'b1, 1'b0, 32'h0000_0333);
    chk_out("fl_reissue", 1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
    step();
    drive(32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("fl_hit", 1'b1, 32'h333, 1'b0, 1'b0, 32'h300);
    step();

    // Address jumps while the 0x304 prefetch is in flight.
    drive(32'h800, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("jmp_pf", 1'b0, 32'h0, 1'b0, 1'b1, 32'h304);
    step();
    drive(32'h800, 1'b0, 1'b1, 1'b0, 32'h0000_304D);
    chk_out("jmp_hold", 1'b0, 32'h0, 1'b0, 1'b1, 32'h304);
    step();
    drive(32'h800, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("jmp_gap", 1'b0, 32'h0, 1'b0, 1'b0, 32'h304);
    step();
    drive(32'h800, 1'b0, 1'b1, 1'b0, 32'h0000_800D);
    chk_out("jmp_dem", 1'b0, 32'h0, 1'b0, 1'b1, 32'h800);
    step();
    drive(32'h800, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("jmp_hit", 1'b1, 32'h800D, 1'b0, 1'b0, 32'h800);
    step();
    drive(32'h800, 1'b0, 1'b1, 1'b0, 32'h0);
    chk_out("jmp_pf2", 1'b1, 32'h800D, 1'b0, 1'b1, 32'h804);
    step();

    // Wrap: prefetch after the top word targets address 0.
    drive(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("wr_miss", 1'b0, 32'h0, 1'b0, 1'b0, 32'h804);
    step();
    drive(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'h0000_F00D);
    chk_out("wr_dem", 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    drive(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("wr_hit", 1'b1, 32'hF00D, 1'b0, 1'b0, 32'hFFFF_FFFC);
    step();
    chk_out("wr_pf", 1'b1, 32'hF00D, 1'b0, 1'b1, 32'h0);

    // Reset mid-BUSY drops the bus cycle without waiting for a clock edge.
    rst_i = 1'b0;
    #1;
    chk_out("rst_busy", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    rst_i = 1'b1;
    step();
    chk_out("rst_after", 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
